// File: rtl/uart_tx8.sv
// rtl/uart_tx8.sv - 8-bit UART transmitter with one-entry holding register
module uart_tx8 #(
    parameter int CLOCK_RATE = 12000000,
    parameter int BAUD_RATE  = 9600,
    parameter int PARITY     = 0,
    parameter int STOP_BITS  = 1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       txEn,
    input  logic       txStart,
    input  logic [7:0] txIn,
    output logic       txReady,
    output logic       txBusy,
    output logic       txDone,
    output logic       txOut
);

    localparam int DIV = CLOCK_RATE / BAUD_RATE;
    localparam int CW  = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CW-1:0] BAUD_LAST = CW'(DIV - 1);
    localparam bit PAR_EN  = (PARITY == 1) || (PARITY == 2);
    localparam bit PAR_ODD = (PARITY == 1);
    // Unsupported stop-bit counts fall back to a single stop bit.
    localparam logic [2:0] STOP_LAST = (STOP_BITS == 2) ? 3'd1 : 3'd0;

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_START  = 3'd1;
    localparam logic [2:0] S_DATA   = 3'd2;
    localparam logic [2:0] S_PARITY = 3'd3;
    localparam logic [2:0] S_STOP   = 3'd4;

    logic [2:0]    state;
    logic [CW-1:0] baud_cnt;
    logic [2:0]    bit_cnt;
    logic [7:0]    shifter;
    logic          par_bit;
    logic [7:0]    hold_data;
    logic          hold_full;

    logic bit_end;
    logic frame_end;
    logic load;
    logic accept;

    // Bit-boundary, end-of-frame, and holding-register handshake decode.
    always_comb begin
        bit_end   = (baud_cnt == BAUD_LAST);
        frame_end = (state == S_STOP) && bit_end && (bit_cnt == STOP_LAST);
        // A new frame starts from IDLE or directly on the last stop-bit edge.
        load      = hold_full && txEn && ((state == S_IDLE) || frame_end);
        accept    = txStart && txEn && !hold_full;
        txReady   = !hold_full;
    end

    // Holding register: filled on an accepted request, emptied when the FSM loads it.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            hold_full <= 1'b0;
            hold_data <= 8'h00;
        end else if (load) begin
            hold_full <= 1'b0;
        end else if (accept) begin
            hold_full <= 1'b1;
            hold_data <= txIn;
        end
    end

    // Frame sequencer: baud timing, bit shifting and line drive.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= S_IDLE;
            baud_cnt <= '0;
            bit_cnt  <= 3'd0;
            shifter  <= 8'h00;
            par_bit  <= 1'b0;
            txOut    <= 1'b1;
            txBusy   <= 1'b0;
            txDone   <= 1'b0;
        end else begin
            txDone <= frame_end;
            if (state == S_IDLE || bit_end) begin
                baud_cnt <= '0;
            end else begin
                baud_cnt <= baud_cnt + 1'b1;
            end
            if (load) begin
                state   <= S_START;
                shifter <= hold_data;
                par_bit <= (^hold_data) ^ PAR_ODD;
                bit_cnt <= 3'd0;
                txOut   <= 1'b0;
                txBusy  <= 1'b1;
            end else begin
                case (state)
                    S_IDLE: begin
                        txOut  <= 1'b1;
                        txBusy <= 1'b0;
                    end
                    S_START: begin
                        if (bit_end) begin
                            state   <= S_DATA;
                            bit_cnt <= 3'd0;
                            txOut   <= shifter[0];
                        end
                    end
                    S_DATA: begin
                        if (bit_end) begin
                            if (bit_cnt == 3'd7) begin
                                bit_cnt <= 3'd0;
                                if (PAR_EN) begin
                                    state <= S_PARITY;
                                    txOut <= par_bit;
                                end else begin
                                    state <= S_STOP;
                                    txOut <= 1'b1;
                                end
                            end else begin
                                bit_cnt <= bit_cnt + 3'd1;
                                shifter <= {1'b0, shifter[7:1]};
                                txOut   <= shifter[1];
                            end
                        end
                    end
                    S_PARITY: begin
                        if (bit_end) begin
                            state   <= S_STOP;
                            bit_cnt <= 3'd0;
                            txOut   <= 1'b1;
                        end
                    end
                    S_STOP: begin
                        if (bit_end) begin
                            if (bit_cnt == STOP_LAST) begin
                                state  <= S_IDLE;
                                txBusy <= 1'b0;
                                txOut  <= 1'b1;
                            end else begin
                                bit_cnt <= bit_cnt + 3'd1;
                            end
                        end
                    end
                    default: begin
                        state  <= S_IDLE;
                        txBusy <= 1'b0;
                        txOut  <= 1'b1;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_uart_tx8.sv
// tb/tb_uart_tx8.sv - self-checking bench for uart_tx8
module tb_uart_tx8;

    localparam int DIV = 8;
    localparam int PM  [3] = '{0, 2, 1};
    localparam int NS  [3] = '{1, 1, 2};
    localparam int LEN [3] = '{10, 11, 12};

    typedef struct {
        logic [7:0] data;
        logic       par_even;
    } vec_t;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       tx_en = 1'b0;
    logic [7:0] tx_in = 8'h00;
    logic [2:0] tx_start = 3'b000;
    logic [2:0] tx_ready, tx_busy, tx_done, tx_out;

    int cyc = 0, tests = 0, fails = 0, epoch = 0;
    int frames [3] = '{0, 0, 0};
    int b2b [3] = '{0, 0, 0};
    int last_end [3] = '{-1, -1, -1};
    int done_cnt [3] = '{0, 0, 0};
    int last_done [3] = '{0, 0, 0};
    int prev_done [3] = '{0, 0, 0};
    vec_t sb [3][$];
    vec_t vecs [9];

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        for (int g = 0; g < 3; g++) begin
            if (tx_done[g] === 1'b1) begin
                done_cnt[g]  <= done_cnt[g] + 1;
                prev_done[g] <= last_done[g];
                last_done[g] <= cyc;
            end
        end
    end

    for (genvar g = 0; g < 3; g++) begin : g_dut
        uart_tx8 #(
            .CLOCK_RATE(DIV * 100),
            .BAUD_RATE (100),
            .PARITY    (PM[g]),
            .STOP_BITS (NS[g])
        ) u_dut (
            .clk    (clk),
            .reset  (reset),
            .txEn   (tx_en),
            .txStart(tx_start[g]),
            .txIn   (tx_in),
            .txReady(tx_ready[g]),
            .txBusy (tx_busy[g]),
            .txDone (tx_done[g]),
            .txOut  (tx_out[g])
        );
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Frame decoder: samples each bit mid-period and scores against the queue.
    task automatic mon(input int g);
        int c0, ep;
        logic [7:0] d;
        logic p, st, stp_ok, busy_ok, dpre, dnow;
        vec_t e;
        forever begin
            if (reset === 1'b1 && tx_out[g] === 1'b0) begin
                c0 = cyc;
                ep = epoch;
                busy_ok = tx_busy[g];
                repeat (DIV / 2) @(negedge clk);
                st = tx_out[g];
                busy_ok &= tx_busy[g];
                for (int b = 0; b < 8; b++) begin
                    repeat (DIV) @(negedge clk);
                    d[b] = tx_out[g];
                    busy_ok &= tx_busy[g];
                end
                p = 1'b0;
                if (PM[g] != 0) begin
                    repeat (DIV) @(negedge clk);
                    p = tx_out[g];
                    busy_ok &= tx_busy[g];
                end
                stp_ok = 1'b1;
                for (int s = 0; s < NS[g]; s++) begin
                    repeat (DIV) @(negedge clk);
                    stp_ok &= tx_out[g];
                    busy_ok &= tx_busy[g];
                end
                repeat (DIV / 2 - 1) @(negedge clk);
                dpre = tx_done[g];
                @(negedge clk);
                dnow = tx_done[g];
                if (ep == epoch) begin
                    if (last_end[g] == c0) b2b[g]++;
                    last_end[g] = cyc;
                    frames[g]++;
                    chk($sformatf("dut%0d start_bit", g), st, 0);
                    chk($sformatf("dut%0d stop_bits", g), stp_ok, 1);
                    chk($sformatf("dut%0d busy_in_frame", g), busy_ok, 1);
                    chk($sformatf("dut%0d done_early", g), dpre, 0);
                    chk($sformatf("dut%0d done_at_len", g), dnow, 1);
                    chk($sformatf("dut%0d frame_expected", g), sb[g].size() != 0, 1);
                    if (sb[g].size() != 0) begin
                        e = sb[g].pop_front();
                        chk($sformatf("dut%0d data", g), d, e.data);
                        if (PM[g] != 0)
                            chk($sformatf("dut%0d parity", g), p, e.par_even ^ (PM[g] == 1));
                    end
                end
            end else begin
                @(negedge clk);
            end
        end
    endtask

    task automatic send(input int g, input logic [7:0] d, input logic pe);
        int n = 0;
        while (tx_ready[g] !== 1'b1 && n < 2000) begin
            @(negedge clk);
            n++;
        end
        chk("ready_wait", n < 2000, 1);
        tx_in = d;
        tx_start[g] = 1'b1;
        sb[g].push_back(vec_t'{d, pe});
        @(negedge clk);
        tx_start[g] = 1'b0;
    endtask

    task automatic send_all(input vec_t v);
        int n = 0;
        while (tx_ready !== 3'b111 && n < 2000) begin
            @(negedge clk);
            n++;
        end
        chk("ready_all_wait", n < 2000, 1);
        tx_in = v.data;
        tx_start = 3'b111;
        for (int g = 0; g < 3; g++) sb[g].push_back(v);
        @(negedge clk);
        tx_start = 3'b000;
    endtask

    task automatic pulse(input logic [2:0] mask, input logic [7:0] d);
        tx_in = d;
        tx_start = mask;
        @(negedge clk);
        tx_start = 3'b000;
    endtask

    task automatic wait_idle();
        int n = 0;
        @(negedge clk);
        while (!(tx_busy === 3'b000 && tx_ready === 3'b111) && n < 5000) begin
            @(negedge clk);
            n++;
        end
        chk("idle_wait", n < 5000, 1);
        repeat (2) @(negedge clk);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        int d0, f, bb, n;
        int fb [3];
        vecs[0] = '{8'hD6, 1'b1};
        vecs[1] = '{8'h00, 1'b0};
        vecs[2] = '{8'hFF, 1'b0};
        vecs[3] = '{8'h01, 1'b1};
        vecs[4] = '{8'h80, 1'b1};
        vecs[5] = '{8'h3C, 1'b0};
        vecs[6] = '{8'h55, 1'b0};
        vecs[7] = '{8'hA7, 1'b1};
        vecs[8] = '{8'h7F, 1'b1};

        fork
            mon(0);
            mon(1);
            mon(2);
        join_none

        tx_en = 1'b1;
        repeat (3) @(negedge clk);
        for (int g = 0; g < 3; g++) begin
            chk($sformatf("rst dut%0d txOut", g), tx_out[g], 1);
            chk($sformatf("rst dut%0d txBusy", g), tx_busy[g], 0);
            chk($sformatf("rst dut%0d txDone", g), tx_done[g], 0);
            chk($sformatf("rst dut%0d txReady", g), tx_ready[g], 1);
        end
        reset = 1'b1;
        repeat (2) @(negedge clk);

        // Single frame and accept-to-start latency
        send(0, 8'hD6, 1'b1);
        chk("t1 ready_low_after_accept", tx_ready[0], 0);
        chk("t1 line_high_after_accept", tx_out[0], 1);
        @(negedge clk);
        chk("t1 line_falls_next_clk", tx_out[0], 0);
        chk("t1 busy_at_start", tx_busy[0], 1);
        chk("t1 ready_back_at_load", tx_ready[0], 1);
        wait_idle();
        chk("t1 done_pulses", done_cnt[0], 1);
        chk("t1 frames", frames[0], 1);

        // Back-to-back frames
        d0 = done_cnt[0];
        bb = b2b[0];
        send(0, 8'hD6, 1'b1);
        send(0, 8'h55, 1'b0);
        wait_idle();
        chk("t2 done_pulses", done_cnt[0] - d0, 2);
        chk("t2 no_gap", b2b[0] - bb, 1);
        chk("t2 done_spacing", last_done[0] - prev_done[0], LEN[0] * DIV);

        // Table: every byte through none/even/odd-parity variants
        for (int g = 0; g < 3; g++) fb[g] = frames[g];
        for (int i = 0; i < 9; i++) begin
            send_all(vecs[i]);
            wait_idle();
        end
        for (int g = 0; g < 3; g++) begin
            chk($sformatf("t3 dut%0d frames", g), frames[g] - fb[g], 9);
            chk($sformatf("t3 dut%0d queue_drained", g), sb[g].size(), 0);
        end

        // Ignored requests: holding register full, then transmitter disabled
        f = frames[0];
        send(0, 8'h3C, 1'b0);
        pulse(3'b001, 8'hFF);
        wait_idle();
        chk("t4 only_queued_sent", frames[0] - f, 1);
        chk("t4 queue_drained", sb[0].size(), 0);
        tx_en = 1'b0;
        pulse(3'b001, 8'hA5);
        chk("t4 ready_stays_high", tx_ready[0], 1);
        repeat (4) @(negedge clk);
        chk("t4 line_idle", tx_out[0], 1);
        chk("t4 not_busy", tx_busy[0], 0);
        tx_en = 1'b1;
        repeat (2 * DIV) @(negedge clk);
        chk("t4 no_frame_after_reenable", frames[0] - f, 1);

        // txEn dropped mid-frame with a byte held
        f = frames[0];
        d0 = done_cnt[0];
        send(0, 8'hD6, 1'b1);
        repeat (3 * DIV) @(negedge clk);
        send(0, 8'h55, 1'b0);
        tx_en = 1'b0;
        n = 0;
        while (done_cnt[0] == d0 && n < 2000) begin
            @(negedge clk);
            n++;
        end
        chk("t5 done_wait", n < 2000, 1);
        repeat (2 * DIV) @(negedge clk);
        chk("t5 one_done", done_cnt[0] - d0, 1);
        chk("t5 first_frame", frames[0] - f, 1);
        chk("t5 line_high", tx_out[0], 1);
        chk("t5 not_busy", tx_busy[0], 0);
        chk("t5 byte_held", tx_ready[0], 0);
        tx_en = 1'b1;
        @(negedge clk);
        chk("t5 start_one_clk_after_en", tx_out[0], 0);
        wait_idle();
        chk("t5 held_frame_sent", frames[0] - f, 2);

        // Asynchronous reset mid-frame
        f = frames[0];
        d0 = done_cnt[0];
        send(0, 8'hD6, 1'b1);
        repeat (3 * DIV) @(negedge clk);
        #1;
        reset = 1'b0;
        epoch++;
        sb[0].delete();
        #1;
        chk("t6 line_high_immediately", tx_out[0], 1);
        chk("t6 busy_low_immediately", tx_busy[0], 0);
        chk("t6 ready_high_immediately", tx_ready[0], 1);
        chk("t6 done_low", tx_done[0], 0);
        @(negedge clk);
        reset = 1'b1;
        repeat (14 * DIV) @(negedge clk);
        chk("t6 no_done", done_cnt[0] - d0, 0);
        chk("t6 no_frame", frames[0] - f, 0);
        send(0, 8'h3C, 1'b0);
        wait_idle();
        chk("t6 frame_after_reset", frames[0] - f, 1);
        chk("t6 queue_drained", sb[0].size(), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
